// File: rtl/regbank_write_queue_if.sv
// Producer-side bundle for the register-bank write queue: ALU and load-unit
// write requests with their valid/ready handshakes.
interface regbank_write_queue_if #(
  parameter int DATA_W = 32
);
  // Handshake: a request transfers at a rising edge where valid and ready are both high.
  // The producer holds addr/data stable while valid is high. Ready never depends on
  // the producer's own valid. The one exception is ld_ready, which looks at alu_valid
  // so that the ALU keeps priority.
  logic              alu_valid;
  logic              alu_ready;
  logic [3:0]        alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [3:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready
  );
endinterface

// File: rtl/regbank_write_queue.sv
// Write-back front end for the 16 x 32 register bank: two-producer in-order FIFO,
// one registered one-hot retirement per cycle, and a per-register pending scoreboard.
module regbank_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  regbank_write_queue_if.slave       wq,
  input  logic                       wb_hold,
  output logic [15:0]                wb_enable,
  output logic [DATA_W-1:0]          wb_din,
  output logic [15:0]                pending,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [3:0]        mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     free;
  logic [CW-1:0]     cnt      [16];
  logic [CW-1:0]     cnt_next [16];
  logic              alu_push, ld_push, pop;
  logic [PW-1:0]     ld_slot;
  logic [3:0]        head_addr;

  assign free         = DEPTH_C - fifo_count;
  assign wq.alu_ready = (free >= ONE_C);
  assign wq.ld_ready  = (free >= (wq.alu_valid ? TWO_C : ONE_C));

  assign alu_push  = wq.alu_valid & wq.alu_ready;
  assign ld_push   = wq.ld_valid & wq.ld_ready;
  assign pop       = (fifo_count != '0) & ~wb_hold;
  assign head_addr = mem_addr[head];
  // Load lands behind the ALU entry when both are accepted together.
  assign ld_slot   = alu_push ? tail + PW'(1) : tail;

  always_ff @(posedge clk) begin
    if (alu_push) begin
      mem_addr[tail] <= wq.alu_addr;
      mem_data[tail] <= wq.alu_data;
    end
    if (ld_push) begin
      mem_addr[ld_slot] <= wq.ld_addr;
      mem_data[ld_slot] <= wq.ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      wb_enable  <= '0;
      wb_din     <= '0;
    end else begin
      tail       <= tail + PW'(alu_push) + PW'(ld_push);
      head       <= head + PW'(pop);
      fifo_count <= fifo_count + CW'(alu_push) + CW'(ld_push) - CW'(pop);
      if (pop) begin
        wb_enable <= 16'(1) << head_addr;
        wb_din    <= mem_data[head];
      end else begin
        wb_enable <= '0;
      end
    end
  end

  // Per-register occupancy; push and pop on the same register net out in one update.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      cnt_next[r] = cnt[r]
                  + CW'(alu_push && (wq.alu_addr == 4'(r)))
                  + CW'(ld_push && (wq.ld_addr == 4'(r)))
                  - CW'(pop && (head_addr == 4'(r)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 16; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 16; r++) cnt[r] <= cnt_next[r];
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < 16; r++) begin
      pending[r] = (cnt[r] != '0) | wb_enable[r];
    end
  end
endmodule

// File: tb/tb_regbank_write_queue.sv
// Directed bench for regbank_write_queue: one task per scenario with inline checks.
module tb_regbank_write_queue;
  logic        clk;
  logic        reset;
  logic        wb_hold;
  logic [15:0] wb_enable;
  logic [31:0] wb_din;
  logic [15:0] pending;
  logic [2:0]  fifo_count;

  int vectors;
  int miscompares;

  // Expected retirements: {one-hot enable, data}.
  logic [47:0] exp_q[$];

  regbank_write_queue_if #(.DATA_W(32)) wq ();

  regbank_write_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .wq         (wq),
    .wb_hold    (wb_hold),
    .wb_enable  (wb_enable),
    .wb_din     (wb_din),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wq.alu_valid = 1'b0;
    wq.alu_addr  = 4'd0;
    wq.alu_data  = 32'd0;
    wq.ld_valid  = 1'b0;
    wq.ld_addr   = 4'd0;
    wq.ld_data   = 32'd0;
  endtask

  task automatic test_reset();
    vectors++;
    if (wb_enable !== 16'h0) begin
      miscompares++; $display("FAIL reset_wb_enable: got %h want %h", wb_enable, 16'h0);
    end
    vectors++;
    if (wb_din !== 32'h0) begin
      miscompares++; $display("FAIL reset_wb_din: got %h want %h", wb_din, 32'h0);
    end
    vectors++;
    if (pending !== 16'h0) begin
      miscompares++; $display("FAIL reset_pending: got %h want %h", pending, 16'h0);
    end
    vectors++;
    if (fifo_count !== 3'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    vectors++;
    if ({wq.alu_ready, wq.ld_ready} !== 2'b11) begin
      miscompares++; $display("FAIL reset_ready: got %b want 11", {wq.alu_ready, wq.ld_ready});
    end
  endtask

  task automatic test_reset_midstream();
    wb_hold = 1'b1;
    wq.alu_valid = 1'b1; wq.alu_addr = 4'd1; wq.alu_data = 32'h101;
    wq.ld_valid  = 1'b1; wq.ld_addr  = 4'd2; wq.ld_data  = 32'h202;
    step();
    wq.alu_addr = 4'd3; wq.alu_data = 32'h303;
    wq.ld_addr  = 4'd4; wq.ld_data  = 32'h404;
    step();
    idle_inputs();
    wb_hold = 1'b0;
    step();
    vectors++;
    if (wb_enable !== 16'h0002 || fifo_count !== 3'd3) begin
      miscompares++;
      $display("FAIL midrst_pre: got en=%h cnt=%0d want en=0002 cnt=3", wb_enable, fifo_count);
    end
    vectors++;
    if (pending !== 16'h001E) begin
      miscompares++; $display("FAIL midrst_pending_pre: got %h want 001e", pending);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (wb_enable !== 16'h0 || pending !== 16'h0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_async: got en=%h pend=%h cnt=%0d want 0 0 0", wb_enable, pending, fifo_count);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (wb_enable !== 16'h0 || fifo_count !== 3'd0 || pending !== 16'h0) begin
        miscompares++;
        $display("FAIL midrst_after_%0d: got en=%h cnt=%0d pend=%h want 0 0 0", i, wb_enable, fifo_count, pending);
      end
    end
  endtask

  task automatic test_single_write();
    wb_hold = 1'b0;
    wq.alu_valid = 1'b1; wq.alu_addr = 4'd5; wq.alu_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (wq.alu_ready !== 1'b1) begin
      miscompares++; $display("FAIL single_ready: got %b want 1", wq.alu_ready);
    end
    step();
    idle_inputs();
    vectors++;
    if (pending !== 16'h0020 || wb_enable !== 16'h0 || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_edge0: got pend=%h en=%h cnt=%0d want 0020 0000 1", pending, wb_enable, fifo_count);
    end
    step();
    vectors++;
    if (wb_enable !== 16'h0020 || wb_din !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL single_retire: got en=%h din=%h want 0020 deadbeef", wb_enable, wb_din);
    end
    vectors++;
    if (pending !== 16'h0020 || fifo_count !== 3'd0) begin
      miscompares++; $display("FAIL single_pend_retire: got pend=%h cnt=%0d want 0020 0", pending, fifo_count);
    end
    step();
    vectors++;
    if (pending !== 16'h0 || wb_enable !== 16'h0 || wb_din !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_edge2: got pend=%h en=%h din=%h want 0000 0000 deadbeef", pending, wb_enable, wb_din);
    end
  endtask

  task automatic test_dual_push();
    wb_hold = 1'b0;
    wq.alu_valid = 1'b1; wq.alu_addr = 4'd3; wq.alu_data = 32'h11;
    wq.ld_valid  = 1'b1; wq.ld_addr  = 4'd7; wq.ld_data  = 32'h22;
    #1;
    vectors++;
    if ({wq.alu_ready, wq.ld_ready} !== 2'b11) begin
      miscompares++; $display("FAIL dual_ready: got %b want 11", {wq.alu_ready, wq.ld_ready});
    end
    step();
    idle_inputs();
    vectors++;
    if (fifo_count !== 3'd2 || pending !== 16'h0088) begin
      miscompares++; $display("FAIL dual_queued: got cnt=%0d pend=%h want 2 0088", fifo_count, pending);
    end
    step();
    vectors++;
    if (wb_enable !== 16'h0008 || wb_din !== 32'h11) begin
      miscompares++; $display("FAIL dual_first: got en=%h din=%h want 0008 00000011", wb_enable, wb_din);
    end
    step();
    vectors++;
    if (wb_enable !== 16'h0080 || wb_din !== 32'h22) begin
      miscompares++; $display("FAIL dual_second: got en=%h din=%h want 0080 00000022", wb_enable, wb_din);
    end
    step();
    vectors++;
    if (wb_enable !== 16'h0 || pending !== 16'h0) begin
      miscompares++; $display("FAIL dual_idle: got en=%h pend=%h want 0 0", wb_enable, pending);
    end
  endtask

  task automatic test_fill_drain();
    logic [47:0] exp;
    wb_hold = 1'b1;
    wq.alu_valid = 1'b1; wq.alu_addr = 4'd10; wq.alu_data = 32'hA0;
    wq.ld_valid  = 1'b1; wq.ld_addr  = 4'd11; wq.ld_data  = 32'hB0;
    exp_q.push_back({16'h0400, 32'hA0});
    exp_q.push_back({16'h0800, 32'hB0});
    step();
    wq.alu_addr = 4'd12; wq.alu_data = 32'hC0;
    wq.ld_addr  = 4'd0;  wq.ld_data  = 32'hD0;
    exp_q.push_back({16'h1000, 32'hC0});
    exp_q.push_back({16'h0001, 32'hD0});
    step();
    vectors++;
    if (fifo_count !== 3'd4) begin
      miscompares++; $display("FAIL fill_count: got %0d want 4", fifo_count);
    end
    vectors++;
    if ({wq.alu_ready, wq.ld_ready} !== 2'b00) begin
      miscompares++; $display("FAIL fill_ready: got %b want 00", {wq.alu_ready, wq.ld_ready});
    end
    vectors++;
    if (pending !== 16'h1C01 || wb_enable !== 16'h0) begin
      miscompares++; $display("FAIL fill_pending: got pend=%h en=%h want 1c01 0000", pending, wb_enable);
    end
    idle_inputs();
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = exp_q.pop_front();
      vectors++;
      if (wb_enable !== exp[47:32] || wb_din !== exp[31:0]) begin
        miscompares++;
        $display("FAIL drain_%0d: got en=%h din=%h want en=%h din=%h", i, wb_enable, wb_din, exp[47:32], exp[31:0]);
      end
    end
    vectors++;
    if (fifo_count !== 3'd0) begin
      miscompares++; $display("FAIL drain_count: got %0d want 0", fifo_count);
    end
    step();
    vectors++;
    if (wb_enable !== 16'h0 || pending !== 16'h0) begin
      miscompares++; $display("FAIL drain_idle: got en=%h pend=%h want 0 0", wb_enable, pending);
    end
  endtask

  task automatic test_same_register();
    logic [31:0] want_din [3];
    want_din[0] = 32'h1; want_din[1] = 32'h2; want_din[2] = 32'h3;
    wb_hold = 1'b1;
    wq.alu_valid = 1'b1; wq.alu_addr = 4'd9;
    for (int i = 0; i < 3; i++) begin
      wq.alu_data = want_din[i];
      step();
    end
    idle_inputs();
    vectors++;
    if (pending !== 16'h0200 || fifo_count !== 3'd3) begin
      miscompares++; $display("FAIL samereg_queued: got pend=%h cnt=%0d want 0200 3", pending, fifo_count);
    end
    wb_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (wb_enable !== 16'h0200 || wb_din !== want_din[i] || pending !== 16'h0200) begin
        miscompares++;
        $display("FAIL samereg_pulse_%0d: got en=%h din=%h pend=%h want 0200 %h 0200", i, wb_enable, wb_din, pending, want_din[i]);
      end
    end
    step();
    vectors++;
    if (pending !== 16'h0 || wb_enable !== 16'h0) begin
      miscompares++; $display("FAIL samereg_clear: got pend=%h en=%h want 0 0", pending, wb_enable);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want_en [3];
    want_en[0] = 16'h0010; want_en[1] = 16'h0040; want_en[2] = 16'h0100;
    wb_hold = 1'b1;
    wq.alu_valid = 1'b1;
    wq.alu_addr = 4'd1; wq.alu_data = 32'h1; step();
    wq.alu_addr = 4'd2; wq.alu_data = 32'h2; step();
    wq.alu_addr = 4'd4; wq.alu_data = 32'h4; step();
    wq.alu_addr = 4'd6; wq.alu_data = 32'h66;
    wq.ld_valid = 1'b1; wq.ld_addr = 4'd8; wq.ld_data = 32'h88;
    #1;
    vectors++;
    if (fifo_count !== 3'd3 || {wq.alu_ready, wq.ld_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_priority: got cnt=%0d rdy=%b want 3 10", fifo_count, {wq.alu_ready, wq.ld_ready});
    end
    step();
    wq.alu_valid = 1'b0;
    #1;
    vectors++;
    if (fifo_count !== 3'd4 || wq.ld_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_full: got cnt=%0d ld_ready=%b want 4 0", fifo_count, wq.ld_ready);
    end
    wb_hold = 1'b0;
    step();
    vectors++;
    if (wb_enable !== 16'h0002 || fifo_count !== 3'd3 || wq.ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_pop: got en=%h cnt=%0d ld_ready=%b want 0002 3 1", wb_enable, fifo_count, wq.ld_ready);
    end
    step();
    wq.ld_valid = 1'b0;
    vectors++;
    if (wb_enable !== 16'h0004 || fifo_count !== 3'd3 || pending !== 16'h0154) begin
      miscompares++;
      $display("FAIL b2b_ld_accept: got en=%h cnt=%0d pend=%h want 0004 3 0154", wb_enable, fifo_count, pending);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (wb_enable !== want_en[i]) begin
        miscompares++; $display("FAIL b2b_drain_%0d: got en=%h want %h", i, wb_enable, want_en[i]);
      end
    end
    vectors++;
    if (wb_din !== 32'h88 || fifo_count !== 3'd0) begin
      miscompares++; $display("FAIL b2b_last: got din=%h cnt=%0d want 00000088 0", wb_din, fifo_count);
    end
    step();
    vectors++;
    if (wb_enable !== 16'h0 || pending !== 16'h0) begin
      miscompares++; $display("FAIL b2b_idle: got en=%h pend=%h want 0 0", wb_enable, pending);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    wb_hold     = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    step();
    test_reset_midstream();
    test_single_write();
    test_dual_push();
    test_fill_drain();
    test_same_register();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
